// File: rtl/sigma_pkg.sv
// Shared types for the sigma memory arbiter: master IDs and their helpers.
package sigma_pkg;

    typedef logic mid_t;

    localparam mid_t MID_DBG = 1'b0;
    localparam mid_t MID_CPU = 1'b1;

    function automatic mid_t other_mid(input mid_t mid);
        return ~mid;
    endfunction

endpackage

// File: rtl/sigma_tag_fifo.sv
// In-order tag FIFO remembering which master owns each outstanding read.
module sigma_tag_fifo
    import sigma_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  mid_t                       din_i,
    output mid_t                       dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    mid_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_r == CNT_W'(DEPTH));
    assign empty_o   = (count_r == {CNT_W{1'b0}});
    assign count_o   = count_r;
    assign dout_o    = mem_r[rd_ptr_r];
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;

    // Occupancy follows push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= MID_DBG;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din_i;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/sigma_mem_arb.sv
// Two-master arbiter for the shared memory port with in-order read routing.
// Define SIGMA_MEM_ARB_RR_EN for round-robin; otherwise the debug master has fixed priority.
module sigma_mem_arb
    import sigma_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PEND_DEPTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_ack_o,
    output logic                m0_resp_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_ack_o,
    output logic                m1_resp_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W/8-1:0] s_be_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic                s_ack_i,
    input  logic                s_resp_i,
    input  logic [DATA_W-1:0]   s_rdata_i,
    output logic                err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(PEND_DEPTH) + 1;

    mid_t             sel_s;
    mid_t             prio_s;
    mid_t             lock_mid_r;
    mid_t             tag_head_s;
    logic             lock_r;
    logic             sel_req_s;
    logic             push_s;
    logic             pop_s;
    logic             tag_full_s;
    logic             tag_empty_s;
    logic [CNT_W-1:0] tag_cnt_s;
    logic             err_r;

    sigma_tag_fifo #(.DEPTH(PEND_DEPTH)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (sel_s),
        .dout_o  (tag_head_s),
        .full_o  (tag_full_s),
        .empty_o (tag_empty_s),
        .count_o (tag_cnt_s)
    );

`ifdef SIGMA_MEM_ARB_RR_EN
    mid_t prio_r;

    // Hand the next contested grant to whichever master was not just served.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_r <= MID_DBG;
        end else if (s_req_o && s_ack_i) begin
            prio_r <= other_mid(sel_s);
        end else begin
            prio_r <= prio_r;
        end
    end

    assign prio_s = prio_r;
`else
    assign prio_s = MID_DBG;
`endif

    // A presented-but-unacked request keeps its master selected.
    always_comb begin
        sel_s = MID_DBG;
        if (lock_r) begin
            sel_s = lock_mid_r;
        end else if (m0_req_i && m1_req_i) begin
            sel_s = prio_s;
        end else if (m1_req_i) begin
            sel_s = MID_CPU;
        end else begin
            sel_s = MID_DBG;
        end
    end

    assign sel_req_s = (sel_s == MID_CPU) ? m1_req_i : m0_req_i;

    // Forward the selected request unless the tag FIFO cannot take another read.
    always_comb begin
        s_req_o   = 1'b0;
        s_we_o    = 1'b0;
        s_addr_o  = {ADDR_W{1'b0}};
        s_be_o    = {BE_W{1'b0}};
        s_wdata_o = {DATA_W{1'b0}};
        m0_ack_o  = 1'b0;
        m1_ack_o  = 1'b0;
        if (!rst_i && sel_req_s && !tag_full_s) begin
            s_req_o = 1'b1;
            case (sel_s)
                MID_CPU: begin
                    s_we_o    = m1_we_i;
                    s_addr_o  = m1_addr_i;
                    s_be_o    = m1_be_i;
                    s_wdata_o = m1_wdata_i;
                    m1_ack_o  = s_ack_i;
                end
                default: begin
                    s_we_o    = m0_we_i;
                    s_addr_o  = m0_addr_i;
                    s_be_o    = m0_be_i;
                    s_wdata_o = m0_wdata_i;
                    m0_ack_o  = s_ack_i;
                end
            endcase
        end else begin
            s_req_o = 1'b0;
        end
    end

    assign push_s = s_req_o && s_ack_i && !s_we_o;
    assign pop_s  = !rst_i && s_resp_i && !tag_empty_s;

    // Route a response to the master at the FIFO head; data is zero otherwise.
    always_comb begin
        m0_resp_o  = 1'b0;
        m1_resp_o  = 1'b0;
        m0_rdata_o = {DATA_W{1'b0}};
        m1_rdata_o = {DATA_W{1'b0}};
        if (pop_s) begin
            case (tag_head_s)
                MID_CPU: begin
                    m1_resp_o  = 1'b1;
                    m1_rdata_o = s_rdata_i;
                end
                default: begin
                    m0_resp_o  = 1'b1;
                    m0_rdata_o = s_rdata_i;
                end
            endcase
        end else begin
            m0_resp_o = 1'b0;
        end
    end

    // Lock the current owner while the memory stalls its request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_r     <= 1'b0;
            lock_mid_r <= MID_DBG;
        end else if (s_ack_i) begin
            lock_r     <= 1'b0;
            lock_mid_r <= lock_mid_r;
        end else if (s_req_o) begin
            lock_r     <= 1'b1;
            lock_mid_r <= sel_s;
        end else begin
            lock_r     <= lock_r;
            lock_mid_r <= lock_mid_r;
        end
    end

    // Sticky flag for a response that had no read waiting for it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (s_resp_i && (tag_cnt_s == {CNT_W{1'b0}})) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err_o = err_r;

endmodule

// File: tb/tb_sigma_mem_arb.sv
// Scoreboard bench for sigma_mem_arb: directed stimulus queues expected acks/responses,
// a negedge monitor pops and compares them.
module tb_sigma_mem_arb;

    typedef struct packed {
        logic        mid;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_o, s_wdata_o;
    logic [3:0]  s_be_o;
    logic        s_ack_i, s_resp_i;
    logic [31:0] s_rdata_i;
    logic        err_o;

    int    checks   = 0;
    int    failures = 0;
    logic  ack_q [$];
    resp_t resp_q [$];

    sigma_mem_arb #(.ADDR_W(32), .DATA_W(32), .PEND_DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i),
        .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i),
        .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
        .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_i(s_rdata_i),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr);
        m0_req_i = req; m0_we_i = we; m0_addr_i = addr;
        m0_be_i = 4'hF; m0_wdata_i = addr ^ 32'hA5A5_0000;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr);
        m1_req_i = req; m1_we_i = we; m1_addr_i = addr;
        m1_be_i = 4'hF; m1_wdata_i = addr ^ 32'h5A5A_0000;
    endtask

    task automatic idle();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b0, 1'b0, 32'h0);
        s_ack_i = 1'b0; s_resp_i = 1'b0; s_rdata_i = 32'h0;
    endtask

    task automatic exp_resp(input logic mid, input logic [31:0] d);
        resp_t r;
        r.mid = mid; r.data = d;
        resp_q.push_back(r);
    endtask

    // Monitor: pop and compare whenever the DUT presents an ack or a response.
    always @(negedge clk) begin : monitor
        logic  e;
        resp_t r;
        if (m0_ack_o || m1_ack_o) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", 64'({m1_ack_o, m0_ack_o}), 64'd0);
            end else begin
                e = ack_q.pop_front();
                chk("ack_mid", 64'({m1_ack_o, m0_ack_o}), e ? 64'd2 : 64'd1);
            end
        end
        if (m0_resp_o || m1_resp_o) begin
            if (resp_q.size() == 0) begin
                chk("resp_unexpected", 64'({m1_resp_o, m0_resp_o}), 64'd0);
            end else begin
                r = resp_q.pop_front();
                chk("resp_mid", 64'({m1_resp_o, m0_resp_o}), r.mid ? 64'd2 : 64'd1);
                chk("resp_data", 64'(r.mid ? m1_rdata_o : m0_rdata_o), 64'(r.data));
                chk("resp_other_zero", 64'(r.mid ? m0_rdata_o : m1_rdata_o), 64'd0);
            end
        end else begin
            chk("rdata_idle_zero", {m0_rdata_o, m1_rdata_o}, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] order;
        rst_i = 1'b1;
        idle();
        tick();
        tick();

        // Reset holds all handshake outputs low even with live inputs.
        drive_m0(1'b1, 1'b0, 32'h1);
        s_ack_i = 1'b1; s_resp_i = 1'b1;
        #1;
        chk("rst_s_req", 64'(s_req_o), 64'd0);
        chk("rst_m0_ack", 64'(m0_ack_o), 64'd0);
        chk("rst_m0_resp", 64'(m0_resp_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        tick();
        rst_i = 1'b0;
        idle();
        tick();

        // Single m1 read, acked immediately, response two cycles later.
        drive_m1(1'b1, 1'b0, 32'h100);
        s_ack_i = 1'b1;
        ack_q.push_back(1'b1);
        #1;
        chk("m1_rd_s_req", 64'(s_req_o), 64'd1);
        chk("m1_rd_addr", 64'(s_addr_o), 64'h100);
        tick();
        idle();
        tick();
        s_resp_i = 1'b1; s_rdata_i = 32'hDEAD_BEEF;
        exp_resp(1'b1, 32'hDEAD_BEEF);
        #1;
        chk("m1_rd_m0_quiet", 64'(m0_resp_o), 64'd0);
        tick();
        idle();
        tick();

        // Continuous contention with writes.
`ifdef SIGMA_MEM_ARB_RR_EN
        order = 3'b010;
`else
        order = 3'b000;
`endif
        drive_m0(1'b1, 1'b1, 32'h10);
        drive_m1(1'b1, 1'b1, 32'h20);
        s_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ack_q.push_back(order[i]);
            #1;
            chk("contend_addr", 64'(s_addr_o), order[i] ? 64'h20 : 64'h10);
            tick();
        end
        idle();
        tick();

        // m1 stalled three cycles; m0 arriving meanwhile must not steal the port.
        drive_m1(1'b1, 1'b1, 32'h300);
        #1; chk("lock_addr0", 64'(s_addr_o), 64'h300);
        tick();
        drive_m0(1'b1, 1'b1, 32'h30);
        #1; chk("lock_addr1", 64'(s_addr_o), 64'h300);
        tick();
        #1; chk("lock_addr2", 64'(s_addr_o), 64'h300);
        tick();
        s_ack_i = 1'b1;
        ack_q.push_back(1'b1);
        #1; chk("lock_addr3", 64'(s_addr_o), 64'h300);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0);
        ack_q.push_back(1'b0);
        #1; chk("lock_next_m0", 64'(s_addr_o), 64'h30);
        tick();
        idle();
        tick();

        // Fill the tag FIFO with four reads, fifth is held until a pop frees a slot.
        s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_m0(1'b1, 1'b0, 32'h40 + 32'(i));
            ack_q.push_back(1'b0);
            tick();
        end
        drive_m0(1'b1, 1'b0, 32'h44);
        #1; chk("full_blocks", 64'(s_req_o), 64'd0);
        tick();
        s_resp_i = 1'b1; s_rdata_i = 32'hA0A0_A0A0;
        exp_resp(1'b0, 32'hA0A0_A0A0);
        #1; chk("full_pop_blocks", 64'(s_req_o), 64'd0);
        tick();
        s_resp_i = 1'b0;
        ack_q.push_back(1'b0);
        #1;
        chk("after_pop_req", 64'(s_req_o), 64'd1);
        chk("after_pop_addr", 64'(s_addr_o), 64'h44);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        s_ack_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_resp_i = 1'b1; s_rdata_i = 32'hB000_0000 + 32'(i);
            exp_resp(1'b0, 32'hB000_0000 + 32'(i));
            tick();
        end
        idle();
        tick();

        // Interleaved reads m0, m1, m0; first response overlaps the last accept.
        drive_m0(1'b1, 1'b0, 32'h50);
        s_ack_i = 1'b1;
        ack_q.push_back(1'b0);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b1, 1'b0, 32'h51);
        ack_q.push_back(1'b1);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0);
        drive_m0(1'b1, 1'b0, 32'h52);
        ack_q.push_back(1'b0);
        s_resp_i = 1'b1; s_rdata_i = 32'h1111_AAAA;
        exp_resp(1'b0, 32'h1111_AAAA);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        s_ack_i = 1'b0;
        s_rdata_i = 32'h2222_BBBB;
        exp_resp(1'b1, 32'h2222_BBBB);
        tick();
        s_rdata_i = 32'h3333_CCCC;
        exp_resp(1'b0, 32'h3333_CCCC);
        tick();
        idle();
        tick();

        // Response with nothing pending is dropped and flagged.
        #1; chk("err_clear", 64'(err_o), 64'd0);
        s_resp_i = 1'b1; s_rdata_i = 32'h5555_5555;
        #1;
        chk("drop_m0", 64'(m0_resp_o), 64'd0);
        chk("drop_m1", 64'(m1_resp_o), 64'd0);
        tick();
        s_resp_i = 1'b0;
        #1; chk("err_set", 64'(err_o), 64'd1);
        tick();
        #1; chk("err_sticky", 64'(err_o), 64'd1);

        // Reset mid-burst with two reads outstanding.
        drive_m0(1'b1, 1'b0, 32'h60);
        s_ack_i = 1'b1;
        ack_q.push_back(1'b0);
        tick();
        drive_m0(1'b1, 1'b0, 32'h61);
        ack_q.push_back(1'b0);
        tick();
        drive_m0(1'b0, 1'b0, 32'h0);
        drive_m1(1'b1, 1'b0, 32'h70);
        rst_i = 1'b1;
        #1;
        chk("midrst_s_req", 64'(s_req_o), 64'd0);
        chk("midrst_m1_ack", 64'(m1_ack_o), 64'd0);
        tick();
        rst_i = 1'b0;
        idle();
        #1; chk("midrst_err", 64'(err_o), 64'd0);
        s_resp_i = 1'b1; s_rdata_i = 32'h6666_6666;
        #1; chk("midrst_stale_drop", 64'(m0_resp_o), 64'd0);
        tick();
        s_resp_i = 1'b0;
        #1; chk("midrst_stale_err", 64'(err_o), 64'd1);
        drive_m1(1'b1, 1'b0, 32'h80);
        s_ack_i = 1'b1;
        ack_q.push_back(1'b1);
        tick();
        drive_m1(1'b0, 1'b0, 32'h0);
        s_ack_i = 1'b0;
        s_resp_i = 1'b1; s_rdata_i = 32'h7777_7777;
        exp_resp(1'b1, 32'h7777_7777);
        tick();
        idle();
        tick();
        tick();

        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sigma_mem_arb.md
# sigma_mem_arb

Two-master, one-slave arbiter for the sigma SoC's shared on-chip memory port. It lets the UART debug bridge (master 0) and the CPU data port (master 1) share the same memory. Read responses are routed back to the correct master through a small in-order tag FIFO. It sits between the masters and the memory inside the sigma top, clocked from the PLL output clock.

## Interface
Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte-enable width is DATA_W/8.
- PEND_DEPTH, 4: maximum number of outstanding read transactions (power of 2, ≥2).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset. One clock domain; reset is synchronous and active-high.
- m0_req_i, m1_req_i  in  1  request valid.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_addr_i, m1_addr_i  in  ADDR_W  address.
- m0_be_i, m1_be_i  in  DATA_W/8  byte enables.
- m0_wdata_i, m1_wdata_i  in  DATA_W  write data.
- m0_ack_o, m1_ack_o  out  1  request accepted.
- m0_resp_o, m1_resp_o  out  1  read data valid.
- m0_rdata_o, m1_rdata_o  out  DATA_W  read data.
- s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o  out  as above  request to memory.
- s_ack_i  in  1  memory accepted the request.
- s_resp_i  in  1  memory read data valid.
- s_rdata_i  in  DATA_W  memory read data.
- err_o  out  1  sticky flag: a response arrived with no read pending.

## Operation
- Master rule: once req is raised, it and its payload are held until the matching ack.
- Selection:
  - If a request is currently locked (presented to the memory but not yet acked), the locked master stays selected.
  - Otherwise the selection follows the priority policy (see Configuration).
- When a request is selected and the tag FIFO is not full:
  - s_req_o=1.
  - The s_* payload is driven combinationally from the selected master's inputs.
- The lock register is set when s_req_o=1 and s_ack_i=0. It is cleared when s_ack_i=1.
- The ack is combinational: mX_ack_o = s_ack_i && s_req_o && (selected master == X).
- On an accepted read (ack && !we), the master ID is pushed into the tag FIFO. Accepted writes push nothing.
- On s_resp_i=1:
  - The FIFO head is popped.
  - If the head is X, then mX_resp_o=1 and mX_rdata_o=s_rdata_i.
  - mX_rdata_o is zero whenever mX_resp_o=0.
- Boundaries:
  - FIFO full: s_req_o=0, even if a pop happens in the same cycle.
  - FIFO empty and s_resp_i=1: the response is dropped, no resp_o is asserted, and err_o is set. err_o clears only on rst_i.
  - Simultaneous push and pop (not full): both take effect; occupancy is unchanged.
  - Occupancy counter width is $clog2(PEND_DEPTH)+1; read/write pointers wrap modulo PEND_DEPTH.
- Reset (a rst_i high at any clock edge, including mid-transaction):
  - FIFO emptied, lock cleared, priority pointer set to master 0, err_o=0.
  - All *_ack_o, *_resp_o, s_req_o are 0 while rst_i=1.
  - Any in-flight responses after reset are handled as the empty-FIFO case.

## Timing
- Request path is combinational: a master's req appears on s_req_o in the same cycle, so 0 added latency.
- Response path is combinational: s_resp_i drives mX_resp_o in the same cycle.
- Registered state updates on the clk_i rising edge: FIFO, lock, priority pointer, err_o.
- Back-to-back requests: one per cycle when the memory acks every cycle.
- Reset values of all registered outputs: err_o=0. All other outputs are combinational and are 0 during reset.

## Configuration
- SIGMA_MEM_ARB_RR_EN defined:
  - Round-robin. The priority pointer toggles to the other master after each ack.
  - Under continuous contention, grants alternate m0, m1, m0, …
- Not defined:
  - Fixed priority: m0 (debug) always wins unlocked arbitration.
  - The priority pointer register is omitted.

## Structure
- Shared package sigma_pkg:
  - Master-ID typedef (1 bit).
  - Constants MID_DBG=0 and MID_CPU=1.
- One sub-module, sigma_tag_fifo: a parameterised synchronous FIFO for tag storage, with full/empty and occupancy outputs.

## Test plan
- m1 read addr 0x100; memory acks in 1 cycle and responds 2 cycles later with 0xDEADBEEF -> m1_ack_o for 1 cycle; m1_resp_o=1 with 0xDEADBEEF; m0 sees nothing.
- m0 and m1 request in the same cycle, memory acks every cycle, RR_EN defined -> ack order m0, m1, m0. Without RR_EN -> m0 acked repeatedly while it keeps requesting.
- m1 presented, memory withholds ack 3 cycles, m0 rises in cycle 1 -> s_addr_o stays m1's until the ack; m0 is granted next.
- PEND_DEPTH=4: four reads acked with no responses -> s_req_o=0 on the fifth. Then one s_resp_i -> the fifth request is forwarded on the following cycle.
- Interleaved reads m0, m1, m0 with responses A, B, C -> m0 gets A, m1 gets B, m0 gets C.
- s_resp_i with empty FIFO -> err_o=1 from the next cycle, no resp_o. rst_i asserted mid-burst -> FIFO empty, err_o=0 after the reset edge.
